alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Decode/operand-fetch stage directly upstream of the ALU. It splits a 32-bit MIPS instruction into fields and reads `rs` and `rt` from an internal 32×32 register file, with write-back bypass. It registers the result into a single-entry ID/EX holding register that drives the ALU inputs (`opcode`, `rs_content`, `rt_content`, `shamt`, `ALU_control`, `immediate`). It uses a valid/ready handshake with stall and flush.

## Interface
- `NREGS`, 32: number of architectural registers; register 0 is hard-wired to zero.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `in_valid` input 1: `instruction` is valid this cycle.
- `in_ready` output 1: the stage accepts `instruction` this cycle.
- `instruction` input 32: raw instruction word.
- `wb_en` input 1: register-file write enable from write-back.
- `wb_addr` input 5: write-back destination register.
- `wb_data` input 32: write-back data.
- `flush` input 1: discard the held entry and any capture this cycle.
- `out_ready` input 1: the ALU side consumes the held entry this cycle.
- `out_valid` output 1: the held entry is valid.
- `opcode` output 6: `instruction[31:26]`.
- `rs_content` output 32: value of register `rs`.
- `rt_content` output 32: value of register `rt`.
- `shamt` output 5: `instruction[10:6]`.
- `ALU_control` output 6: funct field, `instruction[5:0]`.
- `immediate` output 16: `instruction[15:0]`.
- `rs_addr`, `rt_addr` output 5 each: `instruction[25:21]` and `instruction[20:16]`.
- `dest_addr` output 5: `rd` (`instruction[15:11]`) when opcode is 0, otherwise `rt`.

## Operation
- **Register file**
  - On reset, all registers are cleared asynchronously.
  - Writes occur at the rising edge when `wb_en=1` and `wb_addr!=0`.
  - A write with `wb_addr=0` is ignored, and reads of register 0 always return 0.
- **Read with bypass (combinational, in the capture path)**
  - If `wb_en` is set, `wb_addr` equals the source address, and `wb_addr!=0`, the read returns `wb_data`.
  - Otherwise the read returns the register-file contents.
- **Handshake**
  - `in_ready = !out_valid || out_ready`.
  - An instruction is accepted when `in_valid && in_ready && !flush`.
  - On acceptance, all output fields and the bypassed operands are loaded and `out_valid` becomes 1.
- **Consume without new input:** if `out_ready=1`, `out_valid=1`, and nothing is accepted, then `out_valid` becomes 0. Payload outputs keep their last values.
- **Hold-time update:** while an entry is held and not being replaced, a write-back with `wb_en=1` and nonzero `wb_addr` equal to the held `rs_addr` (or `rt_addr`) also updates `rs_content` (or `rt_content`) at that edge. Both are updated if both match. Held operands therefore never go stale.
- **Flush**
  - Highest priority: at the next edge `out_valid` becomes 0 and no instruction is captured, even if `in_valid` is high.
  - Register-file writes still occur during a flush.
- **Two-state control (EMPTY/FULL, encoded by `out_valid`)**
  - EMPTY → FULL on acceptance.
  - FULL → FULL when consumed and replaced in the same cycle, or when held with `out_ready=0`.
  - FULL → EMPTY when consumed with no new acceptance, or on flush.
  - EMPTY → EMPTY on flush or when `in_valid=0`.

## Timing
- **Reset values:** `out_valid=0`; `opcode`, `rs_content`, `rt_content`, `shamt`, `ALU_control`, `immediate`, `rs_addr`, `rt_addr`, and `dest_addr` all 0; all registers 0.
- **Latency:** one cycle. An instruction accepted at edge N appears on the outputs, with `out_valid=1`, after edge N.
- **Throughput:** one instruction per cycle when `out_ready` is held at 1.
- **`in_ready`:** purely combinational from `out_valid` and `out_ready`; it has no combinational dependence on `in_valid` or `flush`.
- **Same-edge write and read:** the write-back at edge N is visible to an instruction captured at edge N, through the bypass.
- **Reset mid-operation:** asserting `rst` clears state immediately, without waiting for a clock edge. After deassertion the first acceptance can occur at the next rising edge.

## Test plan
- **Reset:** assert `rst` with random inputs → all outputs and `out_valid` are 0 immediately. After release, reading any register returns 0.
- **Basic OR operand fetch**
  - Stimulus: write `$5=0x5`, then `$6=0x2`; then with `out_ready=1` present `instruction=0x00A63825` (OR `$7`,`$5`,`$6`).
  - Required response, one cycle later: `out_valid=1`, `opcode=0`, `rs_content=0x5`, `rt_content=0x2`, `ALU_control=6'b100101`, `dest_addr=7`, `shamt=0`.
- **Same-cycle bypass:** write-back of `$5=0x1F` in the cycle `0x00A63825` is accepted → `rs_content=0x1F`. Also check an I-type instruction: `dest_addr` equals `rt`, and `immediate` equals the low 16 bits.
- **Stall with hold-time update**
  - Stimulus: hold `out_ready=0` with an entry held; write `$6=0x0B`.
  - Required response: `in_ready=0`, `out_valid` stays 1, and `rt_content` becomes 0x0B after the edge.
  - Then raise `out_ready` for one cycle with `in_valid=0` → `out_valid` becomes 0.
- **Zero register:** write `$0=0xFFFF`, then read `$0` as `rs` and as `rt` → both read 0, including through the bypass path.
- **Flush priority**
  - Stimulus: with an entry held, assert `flush` together with `in_valid=1` and `out_ready=1`, while also writing `$9=0x77`.
  - Required response: next cycle `out_valid=0` and the instruction is dropped. A later read of `$9` returns 0x77.

Source files
------------

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - MIPS decode/operand fetch with bypassed register file and ID/EX holding register
module alu_operand_stage #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instruction,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [5:0]  opcode,
    output logic [31:0] rs_content,
    output logic [31:0] rt_content,
    output logic [4:0]  shamt,
    output logic [5:0]  ALU_control,
    output logic [15:0] immediate,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [4:0]  dest_addr
);

    localparam logic [5:0] OP_RTYPE = 6'd0;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        wb_write;
    logic [4:0]  dec_rs;
    logic [4:0]  dec_rt;
    logic [4:0]  dec_dest;
    logic [31:0] rs_read;
    logic [31:0] rt_read;
    logic [31:0] regs [NREGS];

    assign dec_rs   = instruction[25:21];
    assign dec_rt   = instruction[20:16];
    assign dec_dest = (instruction[31:26] == OP_RTYPE) ? instruction[15:11] : instruction[20:16];
    assign wb_write = wb_en && (wb_addr != 5'd0);
    assign out_valid = (state == FULL);

    // Register file: register 0 is never written, so it always reads back as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wb_write) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Operand read with write-back bypass so a same-edge write is seen by the capture.
    always_comb begin
        rs_read = 32'd0;
        rt_read = 32'd0;
        if (dec_rs != 5'd0) begin
            rs_read = (wb_write && (wb_addr == dec_rs)) ? wb_data : regs[dec_rs];
        end
        if (dec_rt != 5'd0) begin
            rt_read = (wb_write && (wb_addr == dec_rt)) ? wb_data : regs[dec_rt];
        end
    end

    // Holding-register occupancy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Handshake and next occupancy; flush overrides any capture.
    always_comb begin
        in_ready   = (state == EMPTY) || out_ready;
        accept     = in_valid && in_ready && !flush;
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else if (accept) begin
            state_next = FULL;
        end else if ((state == FULL) && out_ready) begin
            state_next = EMPTY;
        end
    end

    // Payload capture; a held entry tracks write-backs to its sources so it never goes stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode      <= 6'd0;
            rs_content  <= 32'd0;
            rt_content  <= 32'd0;
            shamt       <= 5'd0;
            ALU_control <= 6'd0;
            immediate   <= 16'd0;
            rs_addr     <= 5'd0;
            rt_addr     <= 5'd0;
            dest_addr   <= 5'd0;
        end else if (accept) begin
            opcode      <= instruction[31:26];
            rs_content  <= rs_read;
            rt_content  <= rt_read;
            shamt       <= instruction[10:6];
            ALU_control <= instruction[5:0];
            immediate   <= instruction[15:0];
            rs_addr     <= dec_rs;
            rt_addr     <= dec_rt;
            dest_addr   <= dec_dest;
        end else if (state == FULL) begin
            if (wb_write && (wb_addr == rs_addr)) begin
                rs_content <= wb_data;
            end
            if (wb_write && (wb_addr == rt_addr)) begin
                rt_content <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - self-checking bench for alu_operand_stage
module tb_alu_operand_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [5:0]  opcode;
    logic [31:0] rs_content;
    logic [31:0] rt_content;
    logic [4:0]  shamt;
    logic [5:0]  ALU_control;
    logic [15:0] immediate;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  dest_addr;

    alu_operand_stage #(.NREGS(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid), .opcode(opcode),
        .rs_content(rs_content), .rt_content(rt_content), .shamt(shamt),
        .ALU_control(ALU_control), .immediate(immediate), .rs_addr(rs_addr),
        .rt_addr(rt_addr), .dest_addr(dest_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: architectural registers plus the held instruction word and its operands.
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_rs;
    logic [31:0] m_rt;

    typedef struct {
        logic        iv;
        logic [31:0] instr;
        logic        wbe;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        ordy;
        logic        fl;
        logic        e_inrdy;
        logic        e_valid;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [4:0]  e_dest;
        logic [15:0] e_imm;
        logic [5:0]  e_funct;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && (wb_addr == a)) return wb_data;
        return m_regs[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_valid = 1'b0;
        m_instr = 32'd0;
        m_rs    = 32'd0;
        m_rt    = 32'd0;
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        instruction = 32'd0;
        wb_en       = 1'b0;
        wb_addr     = 5'd0;
        wb_data     = 32'd0;
        flush       = 1'b0;
        out_ready   = 1'b0;
    endtask

    // One clock of the stage: predict from the current inputs, take the edge, compare.
    task automatic do_cycle();
        logic        acc;
        logic        nv;
        logic [31:0] ni;
        logic [31:0] nrs;
        logic [31:0] nrt;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
        acc = in_valid && (!m_valid || out_ready) && !flush;
        ni  = m_instr;
        nrs = m_rs;
        nrt = m_rt;
        if (acc) begin
            ni  = instruction;
            nrs = m_read(instruction[25:21]);
            nrt = m_read(instruction[20:16]);
        end else if (m_valid && wb_en && (wb_addr != 5'd0)) begin
            if (wb_addr == m_instr[25:21]) nrs = wb_data;
            if (wb_addr == m_instr[20:16]) nrt = wb_data;
        end
        if (flush) nv = 1'b0;
        else if (acc) nv = 1'b1;
        else nv = m_valid && !out_ready;
        if (wb_en && (wb_addr != 5'd0)) m_regs[wb_addr] = wb_data;
        @(posedge clk);
        #1;
        m_valid = nv;
        m_instr = ni;
        m_rs    = nrs;
        m_rt    = nrt;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("opcode", 32'(opcode), 32'(m_instr[31:26]));
            chk("rs_content", rs_content, m_rs);
            chk("rt_content", rt_content, m_rt);
            chk("shamt", 32'(shamt), 32'(m_instr[10:6]));
            chk("ALU_control", 32'(ALU_control), 32'(m_instr[5:0]));
            chk("immediate", 32'(immediate), 32'(m_instr[15:0]));
            chk("rs_addr", 32'(rs_addr), 32'(m_instr[25:21]));
            chk("rt_addr", 32'(rt_addr), 32'(m_instr[20:16]));
            chk("dest_addr", 32'(dest_addr),
                32'((m_instr[31:26] == 6'd0) ? m_instr[15:11] : m_instr[20:16]));
        end
    endtask

    // Asynchronous reset with random inputs; outputs must clear before any clock edge.
    task automatic do_reset();
        in_valid    = 1'($urandom);
        instruction = $urandom;
        wb_en       = 1'($urandom);
        wb_addr     = 5'($urandom);
        wb_data     = $urandom;
        flush       = 1'($urandom);
        out_ready   = 1'($urandom);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_rs_content", rs_content, 32'd0);
        chk("rst_rt_content", rt_content, 32'd0);
        chk("rst_shamt", 32'(shamt), 32'd0);
        chk("rst_ALU_control", 32'(ALU_control), 32'd0);
        chk("rst_immediate", 32'(immediate), 32'd0);
        chk("rst_rs_addr", 32'(rs_addr), 32'd0);
        chk("rst_rt_addr", 32'(rt_addr), 32'd0);
        chk("rst_dest_addr", 32'(dest_addr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        model_clear();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        model_clear();

        //          iv    instr          wbe   wba    wbd            ordy  fl    inrdy valid rs             rt             dest   imm         funct
        vecs[0]  = '{1'b0, 32'h0000_0000, 1'b1, 5'd5,  32'h0000_0005, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         5'd0,  16'h0,      6'h0};
        vecs[1]  = '{1'b0, 32'h0000_0000, 1'b1, 5'd6,  32'h0000_0002, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         5'd0,  16'h0,      6'h0};
        vecs[2]  = '{1'b1, 32'h00A6_3825, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0002, 5'd7,  16'h3825,   6'h25};
        vecs[3]  = '{1'b1, 32'h00A6_3825, 1'b1, 5'd5,  32'h0000_001F, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_001F, 32'h0000_0002, 5'd7,  16'h3825,   6'h25};
        vecs[4]  = '{1'b1, 32'h20A8_1234, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_001F, 32'h0000_0000, 5'd8,  16'h1234,   6'h34};
        vecs[5]  = '{1'b1, 32'h00A6_3825, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_001F, 32'h0000_0002, 5'd7,  16'h3825,   6'h25};
        vecs[6]  = '{1'b1, 32'h20A8_1234, 1'b1, 5'd6,  32'h0000_000B, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_001F, 32'h0000_000B, 5'd7,  16'h3825,   6'h25};
        vecs[7]  = '{1'b0, 32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         5'd0,  16'h0,      6'h0};
        vecs[8]  = '{1'b0, 32'h0000_0000, 1'b1, 5'd0,  32'h0000_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         5'd0,  16'h0,      6'h0};
        vecs[9]  = '{1'b1, 32'h0000_0825, 1'b1, 5'd0,  32'h0000_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 5'd1,  16'h0825,   6'h25};
        vecs[10] = '{1'b1, 32'h00A6_3825, 1'b1, 5'd9,  32'h0000_0077, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         5'd0,  16'h0,      6'h0};
        vecs[11] = '{1'b1, 32'h0129_5025, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0077, 32'h0000_0077, 5'd10, 16'h5025,   6'h25};
        vecs[12] = '{1'b0, 32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0077, 32'h0000_0077, 5'd10, 16'h5025,   6'h25};

        #3;
        do_reset();

        for (int i = 0; i < 13; i++) begin
            in_valid    = vecs[i].iv;
            instruction = vecs[i].instr;
            wb_en       = vecs[i].wbe;
            wb_addr     = vecs[i].wba;
            wb_data     = vecs[i].wbd;
            out_ready   = vecs[i].ordy;
            flush       = vecs[i].fl;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_inrdy));
            do_cycle();
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d_rs_content", i), rs_content, vecs[i].e_rs);
                chk($sformatf("vec%0d_rt_content", i), rt_content, vecs[i].e_rt);
                chk($sformatf("vec%0d_dest_addr", i), 32'(dest_addr), 32'(vecs[i].e_dest));
                chk($sformatf("vec%0d_immediate", i), 32'(immediate), 32'(vecs[i].e_imm));
                chk($sformatf("vec%0d_ALU_control", i), 32'(ALU_control), 32'(vecs[i].e_funct));
            end
        end

        // Reset while an entry is held, then read previously written registers.
        do_reset();
        in_valid    = 1'b1;
        instruction = 32'h00A6_3825;
        out_ready   = 1'b1;
        do_cycle();
        chk("post_reset_valid", 32'(out_valid), 32'd1);
        chk("post_reset_rs", rs_content, 32'd0);
        chk("post_reset_rt", rt_content, 32'd0);

        // Randomised traffic with narrow register range to exercise bypass and hold updates.
        for (int n = 0; n < 400; n++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            wb_en       = 1'($urandom);
            wb_addr     = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            instruction = {($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom),
                           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            do_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
